// File: rtl/rmw_tbl_lkup.sv
`default_nettype none
// ============================================================================
// rmw_tbl_lkup : fixed-latency table lookup with writeback and clear-on-reset
// Rev 1.0
// ============================================================================
module rmw_tbl_lkup #(
  parameter int IDX_W        = 8,
  parameter int LAT          = 16,
  parameter int INFLIGHT_MAX = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lkup_vld,
  input  logic [15:0] lkup_id,
  input  logic [5:0]  lkup_tag,
  output logic        lkup_rdy,
  output logic        rsp_vld,
  output logic [5:0]  rsp_tag,
  output logic [31:0] rsp_word,
  input  logic        wrbk_vld,
  input  logic [15:0] wrbk_id,
  input  logic [31:0] wrbk_word,
  output logic        init_done,
  output logic [6:0]  inflight
);

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [6:0] MAX_CNT = 7'(INFLIGHT_MAX);

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] init_idx;
  logic [31:0]      mem [2**IDX_W];

  logic [LAT-1:0]   pipe_vld;
  logic [5:0]       pipe_tag  [LAT];
  logic [31:0]      pipe_word [LAT];

  logic [IDX_W-1:0] lkup_idx;
  logic [IDX_W-1:0] wrbk_idx;
  logic             accept;
  logic             wrbk_en;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [31:0]      wr_data;
  logic [31:0]      rd_word;
  logic             unused_id_bits;

  assign lkup_idx       = lkup_id[IDX_W-1:0];
  assign wrbk_idx       = wrbk_id[IDX_W-1:0];
  assign unused_id_bits = ^{lkup_id[15:IDX_W], wrbk_id[15:IDX_W]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= INIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    lkup_rdy  = 1'b0;
    init_done = 1'b0;
    case (state)
      INIT: begin
        if (init_idx == '1) state_nxt = RUN;
      end
      RUN: begin
        lkup_rdy  = (inflight < MAX_CNT);
        init_done = 1'b1;
      end
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              init_idx <= '0;
    else if (state == INIT)  init_idx <= init_idx + 1'b1;
  end

  // Writebacks are only honoured in RUN; INIT owns the write port for clearing.
  assign wrbk_en = wrbk_vld && (state == RUN);
  assign wr_en   = (state == INIT) || wrbk_en;
  assign wr_idx  = (state == INIT) ? init_idx : wrbk_idx;
  assign wr_data = (state == INIT) ? 32'd0 : wrbk_word;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  assign accept  = lkup_vld && lkup_rdy;
  assign rd_word = (wrbk_en && (wrbk_idx == lkup_idx)) ? wrbk_word : mem[lkup_idx];

  // Idle stages carry zeros so the response fields are zero whenever rsp_vld is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      for (int i = 0; i < LAT; i++) begin
        pipe_tag[i]  <= '0;
        pipe_word[i] <= '0;
      end
    end else begin
      pipe_vld     <= {pipe_vld[LAT-2:0], accept};
      pipe_tag[0]  <= accept ? lkup_tag : 6'd0;
      pipe_word[0] <= accept ? rd_word : 32'd0;
      for (int i = 1; i < LAT; i++) begin
        pipe_tag[i]  <= pipe_tag[i-1];
        pipe_word[i] <= pipe_word[i-1];
      end
    end
  end

  assign rsp_vld  = pipe_vld[LAT-1];
  assign rsp_tag  = pipe_tag[LAT-1];
  assign rsp_word = pipe_word[LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      case ({accept, rsp_vld})
        2'b10:   inflight <= inflight + 7'd1;
        2'b01:   inflight <= inflight - 7'd1;
        default: inflight <= inflight;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(state == INIT && wrbk_vld));
      assert (inflight <= MAX_CNT);
      assert (!(rsp_vld && !accept && inflight == 7'd0));
    end
  end

endmodule
`default_nettype wire
